// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit for a single-cycle core.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with sign correction applied once at the end. One operation in flight.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               request, accepted only while busy=0 (IDLE or DONE)
//   funct3              0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a, op_b          rs1 / rs2 values
//   rd_in               destination register index
//   busy                operation in progress (CALC or FIX)
//   done                one-cycle pulse, wb_data/wb_rd valid
//   wb_we               done && wb_rd != 0
//   wb_rd, wb_data      destination index and result, held until the next FIX
//
// Optional feature: define MDU_EARLY_OUT_EN to skip the iteration phase when a
// multiply has a zero operand or a divide has a zero divisor.

module mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [REGW-1:0]  rd_in,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [REGW-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       fn_q, fn_nxt;
  logic             neg_q, neg_nxt;   // final result must be negated
  logic             bz_q, bz_nxt;     // divisor was zero
  logic [WIDTH-1:0] opm_q, opm_nxt;   // multiplicand or divisor magnitude
  logic [PW-1:0]    acc_q, acc_nxt;   // mul: {hi, multiplier}; div: {rem, quot}
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [REGW-1:0]  rd_q, rd_nxt;
  logic [REGW-1:0]  wb_rd_nxt;
  logic [WIDTH-1:0] wb_data_nxt;
  logic             accept;

  // Signedness and magnitudes of the incoming request
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_sgn = op_a[WIDTH-1];
        b_sgn = op_b[WIDTH-1];
      end
      3'd2:    a_sgn = op_a[WIDTH-1];
      default: ;
    endcase
    a_mag = a_sgn ? WIDTH'(-op_a) : op_a;
    b_mag = b_sgn ? WIDTH'(-op_b) : op_b;
  end

  // One iteration of each algorithm on the current accumulator
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [PW-1:0]    acc_mul, acc_div;

  always_comb begin
    mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opm_q} : (WIDTH+1)'(0));
    acc_mul   = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opm_q};
    // When div_ge holds the difference is below 2^WIDTH, so the modular subtract is exact
    div_diff  = div_shift[WIDTH-1:0] - opm_q;
    acc_div   = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Sign correction and half/quotient/remainder selection
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem, fix_res;

  always_comb begin
    prod = neg_q ? PW'(-acc_q) : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[PW-1:WIDTH];
    case (fn_q)
      3'd0:             fix_res = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[PW-1:WIDTH];
      3'd4, 3'd5:       fix_res = bz_q ? {WIDTH{1'b1}} : (neg_q ? WIDTH'(-quo) : quo);
      default:          fix_res = neg_q ? WIDTH'(-rem) : rem;
    endcase
  end

  // Next-state and datapath load control
  always_comb begin
    state_nxt   = state;
    fn_nxt      = fn_q;
    neg_nxt     = neg_q;
    bz_nxt      = bz_q;
    opm_nxt     = opm_q;
    acc_nxt     = acc_q;
    cnt_nxt     = cnt_q;
    rd_nxt      = rd_q;
    wb_rd_nxt   = wb_rd;
    wb_data_nxt = wb_data;
    accept      = start && ((state == IDLE) || (state == DONE));

    case (state)
      CALC: begin
        acc_nxt = fn_q[2] ? acc_div : acc_mul;
        cnt_nxt = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX: begin
        wb_data_nxt = fix_res;
        wb_rd_nxt   = rd_q;
        state_nxt   = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: ;
    endcase

    if (accept) begin
      state_nxt = CALC;
      fn_nxt    = funct3;
      // Remainders take the dividend sign; everything else the xor of signs
      neg_nxt   = (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
      bz_nxt    = (op_b == '0);
      opm_nxt   = funct3[2] ? b_mag : a_mag;
      acc_nxt   = {WIDTH'(0), funct3[2] ? a_mag : b_mag};
      cnt_nxt   = '0;
      rd_nxt    = rd_in;
`ifdef MDU_EARLY_OUT_EN
      // Preload what the full iteration would have produced, then go straight to FIX
      if (funct3[2] ? (op_b == '0) : ((op_a == '0) || (op_b == '0))) begin
        state_nxt = FIX;
        acc_nxt   = funct3[2] ? {a_mag, {WIDTH{1'b1}}} : PW'(0);
      end
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fn_q    <= '0;
      neg_q   <= 1'b0;
      bz_q    <= 1'b0;
      opm_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      state   <= state_nxt;
      fn_q    <= fn_nxt;
      neg_q   <= neg_nxt;
      bz_q    <= bz_nxt;
      opm_q   <= opm_nxt;
      acc_q   <= acc_nxt;
      cnt_q   <= cnt_nxt;
      rd_q    <= rd_nxt;
      busy    <= (state_nxt == CALC) || (state_nxt == FIX);
      done    <= (state_nxt == DONE);
      wb_we   <= (state_nxt == DONE) && (wb_rd_nxt != '0);
      wb_rd   <= wb_rd_nxt;
      wb_data <= wb_data_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, hand-written
// multi-cycle sequences, and random operations against an arithmetic model.

module tb_mdu_seq;

  localparam int unsigned W = 32;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b;
  logic [4:0]   rd_in;
  logic         busy, done, wb_we;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_seq #(.WIDTH(W), .REGW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sbu = ub;
    case (f)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sbu; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic early;
    early = f[2] ? (b == 0) : ((a == 0) || (b == 0));
    return (EARLY_EN && early) ? 1 : 33;
  endfunction

  // Issue one op at a negedge; returns at the negedge where done is seen.
  // lat = posedges after the accept edge; busy_ok = busy stayed high until done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] d, output logic [4:0] r,
                        output logic we, output int lat, output bit busy_ok);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    d = wb_data; r = wb_rd; we = wb_we;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    logic        we;
    int          lat;
    bit          bok;
    int          cnt;
    bit          saw_done;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd7,         32'd0,         5'd7,  32'hFFFF_FFFF};
    vecs[7]  = '{3'd7, 32'd7,         32'd0,         5'd8,  32'd7};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0};
    vecs[10] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         5'd11, 32'hFFFF_FFFF};
    vecs[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd12, 32'hFFFF_FFFB};
    vecs[12] = '{3'd0, 32'd0,         32'd5,         5'd0,  32'd0};
    vecs[13] = '{3'd5, 32'd100,       32'd7,         5'd31, 32'd14};
    vecs[14] = '{3'd7, 32'd100,       32'd7,         5'd13, 32'd2};
    vecs[15] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'd0};
    vecs[16] = '{3'd3, 32'h0001_0000, 32'h0001_0000, 5'd15, 32'd1};

    reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_wb_we", 32'(wb_we), 32'd0);
    chk("reset_wb_rd", 32'(wb_rd), 32'd0);
    chk("reset_wb_data", wb_data,  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, d, r, we, lat, bok);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_rd", i), 32'(r), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].rd != 0));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
      chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_data_held", i), wb_data, vecs[i].exp);
    end

    // Back-to-back: second op issued in the DONE cycle of the first
    run_op(3'd0, 32'd6, 32'd9, 5'd3, d, r, we, lat, bok);
    chk("b2b_first_data", d, 32'd54);
    run_op(3'd4, 32'd100, 32'hFFFF_FFF6, 5'd4, d, r, we, lat, bok);
    chk("b2b_second_data", d, 32'hFFFF_FFF6);
    chk("b2b_second_rd", 32'(r), 32'd4);
    chk("b2b_second_latency", 32'(lat), 32'd33);
    @(negedge clk);

    // Start while busy must be ignored
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd20; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("ignore_done_seen", 32'(done), 32'd1);
    chk("ignore_data", wb_data, 32'd14);
    chk("ignore_rd", 32'(wb_rd), 32'd9);
    chk("ignore_latency", 32'(cnt + 6), 32'd33);
    @(negedge clk);

    // Reset mid-divide: outputs clear at once and no done follows
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd17; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy",    32'(busy),  32'd0);
    chk("midrst_done",    32'(done),  32'd0);
    chk("midrst_wb_we",   32'(wb_we), 32'd0);
    chk("midrst_wb_rd",   32'(wb_rd), 32'd0);
    chk("midrst_wb_data", wb_data,    32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd17, d, r, we, lat, bok);
    chk("post_reset_data", d, 32'd333);
    @(negedge clk);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      run_op(f, a, b, rd, d, r, we, lat, bok);
      chk($sformatf("rand%0d_f%0d_a%08h_b%08h_data", i, f, a, b), d, ref_mdu(f, a, b));
      chk($sformatf("rand%0d_we", i), 32'(we), 32'(rd != 0));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(f, a, b)));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
